// File: rtl/sonar_pkg.sv
// Shared types and constants for the multi-channel ultrasonic ranging front end.
package sonar_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    TRIGGER     = 4'd2,
    ESPERA_ECHO = 4'd3,
    MEDE        = 4'd4,
    ARMAZENA    = 4'd5,
    PRONTO      = 4'd6,
    PAUSA       = 4'd7
  } estado_t;

  localparam logic [11:0] MEDIDA_ERRO = 12'hFFF;

  localparam int CICLOS_CM_PADRAO       = 2941;
  localparam int LARGURA_TRIGGER_PADRAO = 500;
  localparam int TIMEOUT_PADRAO         = 1_500_000;
  localparam int INTERVALO_PADRAO       = 3_000_000;

  // Three-digit BCD increment that sticks at 999 instead of wrapping.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] u;
    {c, d, u} = v;
    if (v == 12'h999) begin
      return v;
    end
    if (u != 4'd9) begin
      u = u + 4'd1;
    end else begin
      u = 4'd0;
      if (d != 4'd9) begin
        d = d + 4'd1;
      end else begin
        d = 4'd0;
        c = c + 4'd1;
      end
    end
    return {c, d, u};
  endfunction

endpackage

// File: rtl/contador_cm_bcd.sv
// Cycle prescaler feeding a saturating 3-digit BCD centimetre counter.
// bcd_prox_o is the value the counter takes on the next edge, rounding included.
module contador_cm_bcd
  import sonar_pkg::*;
#(
  parameter int CICLOS_CM = CICLOS_CM_PADRAO
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        limpa_i,
  input  logic        conta_i,
  input  logic        arredonda_i,
  output logic [11:0] bcd_prox_o
);

  localparam int PW = (CICLOS_CM > 1) ? $clog2(CICLOS_CM) : 1;

  logic [PW-1:0] ciclos_q, ciclos_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          meio;

  always_comb begin
    ciclos_d = ciclos_q;
    bcd_d    = bcd_q;
    meio     = (32'(ciclos_q) >= 32'(CICLOS_CM / 2));
    if (limpa_i) begin
      ciclos_d = '0;
      bcd_d    = '0;
    end else if (conta_i) begin
      if (ciclos_q == PW'(CICLOS_CM - 1)) begin
        ciclos_d = '0;
        bcd_d    = bcd_inc(bcd_q);
      end else begin
        ciclos_d = ciclos_q + 1'b1;
      end
    end else if (arredonda_i && meio) begin
      bcd_d = bcd_inc(bcd_q);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ciclos_q <= '0;
      bcd_q    <= '0;
    end else begin
      ciclos_q <= ciclos_d;
      bcd_q    <= bcd_d;
    end
  end

  assign bcd_prox_o = bcd_d;

endmodule

// File: rtl/sonar_ultrassom_multicanal.sv
// Multi-channel ultrasonic ranging FSM: trigger, echo timing, BCD distance per channel.
// Optional rounding of the residual half-centimetre: define MEDIDA_ARREDONDA_EN.
module sonar_ultrassom_multicanal
  import sonar_pkg::*;
#(
  parameter int  N_CANAIS         = 2,
  parameter int  CICLOS_CM        = CICLOS_CM_PADRAO,
  parameter int  LARGURA_TRIGGER  = LARGURA_TRIGGER_PADRAO,
  parameter int  TIMEOUT_CICLOS   = TIMEOUT_PADRAO,
  parameter int  INTERVALO_CICLOS = INTERVALO_PADRAO,
  localparam int CW               = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                medir,
  input  logic                modo,
  input  logic [CW-1:0]       canal,
  input  logic [N_CANAIS-1:0] echo,
  output logic [N_CANAIS-1:0] trigger,
  output logic [11:0]         medida,
  output logic [CW-1:0]       canal_medida,
  output logic                pronto,
  output logic                timeout,
  output logic                ocupado,
  output logic [3:0]          db_estado
);

`ifdef MEDIDA_ARREDONDA_EN
  localparam logic ARREDONDA = 1'b1;
`else
  localparam logic ARREDONDA = 1'b0;
`endif

  estado_t       state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic          modo_q, modo_d;
  logic [31:0]   timer_q, timer_d;
  logic          erro_q, erro_d;
  logic [11:0]   medida_q, medida_d;
  logic [CW-1:0] canal_medida_q, canal_medida_d;
  logic          timeout_q, timeout_d;

  logic [N_CANAIS-1:0] sync1_q, sync2_q;
  logic                echo_sel;
  logic                limpa, conta, arredonda;
  logic [11:0]         bcd_prox;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= echo;
      sync2_q <= sync1_q;
    end
  end

  assign echo_sel = sync2_q[ch_q];

  contador_cm_bcd #(.CICLOS_CM(CICLOS_CM)) u_contador (
    .clock_i     (clock),
    .reset_i     (reset),
    .limpa_i     (limpa),
    .conta_i     (conta),
    .arredonda_i (arredonda),
    .bcd_prox_o  (bcd_prox)
  );

  // Handshake: medir is a request accepted only while ocupado=0; each accepted
  // request produces one pronto pulse per channel, with medida/canal_medida/timeout
  // stable from that pulse until the next one.
  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    modo_d         = modo_q;
    timer_d        = timer_q;
    erro_d         = erro_q;
    medida_d       = medida_q;
    canal_medida_d = canal_medida_q;
    timeout_d      = timeout_q;
    limpa          = 1'b0;
    conta          = 1'b0;
    arredonda      = 1'b0;
    case (state_q)
      INICIAL: begin
        if (medir) begin
          state_d = PREPARA;
          ch_d    = modo ? '0 : canal;
          modo_d  = modo;
        end
      end
      PREPARA: begin
        limpa   = 1'b1;
        timer_d = '0;
        erro_d  = 1'b0;
        state_d = TRIGGER;
      end
      TRIGGER: begin
        if (timer_q == 32'(LARGURA_TRIGGER - 1)) begin
          timer_d = '0;
          state_d = ESPERA_ECHO;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ESPERA_ECHO: begin
        // The cycle that sees the echo rise is already part of the width.
        if (echo_sel) begin
          conta   = 1'b1;
          timer_d = '0;
          state_d = MEDE;
        end else if (timer_q == 32'(TIMEOUT_CICLOS - 1)) begin
          erro_d  = 1'b1;
          state_d = ARMAZENA;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      MEDE: begin
        if (!echo_sel) begin
          state_d = ARMAZENA;
        end else if (timer_q == 32'(TIMEOUT_CICLOS - 1)) begin
          erro_d  = 1'b1;
          state_d = ARMAZENA;
        end else begin
          conta   = 1'b1;
          timer_d = timer_q + 32'd1;
        end
      end
      ARMAZENA: begin
        arredonda      = ARREDONDA;
        medida_d       = erro_q ? MEDIDA_ERRO : bcd_prox;
        canal_medida_d = ch_q;
        timeout_d      = erro_q;
        state_d        = PRONTO;
      end
      PRONTO: begin
        if (modo_q && (ch_q < CW'(N_CANAIS - 1))) begin
          ch_d    = ch_q + 1'b1;
          timer_d = '0;
          state_d = PAUSA;
        end else begin
          state_d = INICIAL;
        end
      end
      PAUSA: begin
        if (timer_q == 32'(INTERVALO_CICLOS - 1)) begin
          state_d = PREPARA;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= INICIAL;
      ch_q           <= '0;
      modo_q         <= 1'b0;
      timer_q        <= '0;
      erro_q         <= 1'b0;
      medida_q       <= '0;
      canal_medida_q <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      modo_q         <= modo_d;
      timer_q        <= timer_d;
      erro_q         <= erro_d;
      medida_q       <= medida_d;
      canal_medida_q <= canal_medida_d;
      timeout_q      <= timeout_d;
    end
  end

  always_comb begin
    trigger = '0;
    if (state_q == TRIGGER) begin
      trigger[ch_q] = 1'b1;
    end
  end

  assign medida       = medida_q;
  assign canal_medida = canal_medida_q;
  assign timeout      = timeout_q;
  assign pronto       = (state_q == PRONTO);
  assign ocupado      = (state_q != INICIAL);
  assign db_estado    = state_q;

endmodule

// File: tb/tb_sonar_ultrassom_multicanal.sv
// Directed and randomized bench for sonar_ultrassom_multicanal with scaled timing
// parameters and an arithmetic distance model.
module tb_sonar_ultrassom_multicanal;

  localparam int N   = 2;
  localparam int C   = 8;
  localparam int L   = 10;
  localparam int TO  = 9000;
  localparam int INT = 50;

  logic         clock = 1'b0;
  logic         reset;
  logic         medir;
  logic         modo;
  logic [0:0]   canal;
  logic [N-1:0] echo;
  logic [N-1:0] trigger;
  logic [11:0]  medida;
  logic [0:0]   canal_medida;
  logic         pronto;
  logic         timeout;
  logic         ocupado;
  logic [3:0]   db_estado;

  sonar_ultrassom_multicanal #(
    .N_CANAIS         (N),
    .CICLOS_CM        (C),
    .LARGURA_TRIGGER  (L),
    .TIMEOUT_CICLOS   (TO),
    .INTERVALO_CICLOS (INT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .medir        (medir),
    .modo         (modo),
    .canal        (canal),
    .echo         (echo),
    .trigger      (trigger),
    .medida       (medida),
    .canal_medida (canal_medida),
    .pronto       (pronto),
    .timeout      (timeout),
    .ocupado      (ocupado),
    .db_estado    (db_estado)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];  // {timeout, canal[2:0], medida}
  int last_pr_cyc;
  int trig_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] modelo(input int w);
    int cm;
    if (w == 0 || w >= TO) return 12'hFFF;
    cm = w / C;
`ifdef MEDIDA_ARREDONDA_EN
    if ((w % C) >= C / 2) cm++;
`endif
    if (cm > 999) cm = 999;
    return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
  endfunction

  function automatic logic [15:0] esperado(input int ch, input int w);
    logic to;
    to = (w == 0 || w >= TO);
    return {to, 3'(ch), modelo(w)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic iniciar(input logic m, input int ch);
    modo  = m;
    canal = 1'(ch);
    medir = 1'b1;
    tick();
    medir = 1'b0;
    modo  = 1'($urandom);
    canal = 1'($urandom);
  endtask

  task automatic medicao(input int ch, input int w, input string tag);
    int n;
    int oth;
    int fall_cyc;
    int pr_cyc;
    bit viu;
    logic pr_after;
    logic [11:0] med;
    logic [0:0] cm;
    logic to;
    logic [15:0] exp;
    oth = 1 - ch;
    n = 0;
    while (!trigger[ch] && n < 200) begin
      tick();
      n++;
    end
    trig_cyc = cyc;
    check({tag, "_trigger_onehot"}, 32'(trigger), 32'd1 << ch);
    n = 0;
    while (trigger != '0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_trigger_largura"}, n, L);
    viu = 0;
    fall_cyc = 0;
    pr_cyc = 0;
    fork
      begin
        echo = '0;
        echo[oth] = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < w; i++) begin
          echo[ch] = 1'b1;
          if (i == 5) echo[oth] = 1'b0;
          medir = (i == 3);
          tick();
        end
        medir = 1'b0;
        echo = '0;
        fall_cyc = cyc;
      end
      begin
        n = 0;
        while (!viu && n < 12000) begin
          tick();
          n++;
          if (pronto) begin
            viu = 1;
            pr_cyc = cyc;
            med = medida;
            cm = canal_medida;
            to = timeout;
            tick();
            pr_after = pronto;
          end
        end
      end
    join
    last_pr_cyc = pr_cyc;
    check({tag, "_pronto_visto"}, 32'(viu), 32'd1);
    check({tag, "_fila_nao_vazia"}, 32'(exp_q.size() > 0), 32'd1);
    if (viu && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, "_medida"}, 32'(med), 32'(exp[11:0]));
      check({tag, "_canal_medida"}, 32'(cm), 32'(exp[14:12]));
      check({tag, "_timeout"}, 32'(to), 32'(exp[15]));
      check({tag, "_pronto_1ciclo"}, 32'(pr_after), 32'd0);
      if (!exp[15]) begin
        check({tag, "_latencia"}, 32'((pr_cyc - fall_cyc) >= 3 && (pr_cyc - fall_cyc) <= 5), 32'd1);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int ch;
    int n;
    int pr0;
    reset = 1'b1;
    medir = 1'b0;
    modo  = 1'b0;
    canal = '0;
    echo  = '0;
    repeat (3) tick();
    check("rst_trigger", 32'(trigger), 32'd0);
    check("rst_medida", 32'(medida), 32'h000);
    check("rst_canal_medida", 32'(canal_medida), 32'd0);
    check("rst_pronto", 32'(pronto), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_db_estado", 32'(db_estado), 32'd0);
    reset = 1'b0;
    tick();

    // single channel 0, 100 cm
    exp_q.push_back(esperado(0, 100 * C + 2));
    iniciar(1'b0, 0);
    check("t1_estado_prepara", 32'(db_estado), 32'd1);
    check("t1_ocupado", 32'(ocupado), 32'd1);
    check("t1_trigger_prepara", 32'(trigger), 32'd0);
    medicao(0, 100 * C + 2, "t1");
    check("t1_volta_inicial", 32'(db_estado), 32'd0);
    check("t1_medida_100", 32'(medida), 32'h100);

    // channel 1: 74.75 cm (rounding-dependent) and 170 cm
    exp_q.push_back(esperado(1, 74 * C + 6));
    iniciar(1'b0, 1);
    medicao(1, 74 * C + 6, "t2_074");
    exp_q.push_back(esperado(1, 170 * C + 1));
    iniciar(1'b0, 1);
    medicao(1, 170 * C + 1, "t2_170");

    // echo shorter than half a centimetre
    exp_q.push_back(esperado(0, 2));
    iniciar(1'b0, 0);
    medicao(0, 2, "t3_curto");

    // no echo, then a good measurement clears the timeout flag
    exp_q.push_back(esperado(0, 0));
    iniciar(1'b0, 0);
    medicao(0, 0, "t4_sem_echo");
    exp_q.push_back(esperado(0, 100 * C + 2));
    iniciar(1'b0, 0);
    medicao(0, 100 * C + 2, "t4_limpa_timeout");

    // echo too long, and echo long enough to saturate
    exp_q.push_back(esperado(1, TO + 500));
    iniciar(1'b0, 1);
    medicao(1, TO + 500, "t5_echo_longo");
    exp_q.push_back(esperado(1, 999 * C + 500));
    iniciar(1'b0, 1);
    medicao(1, 999 * C + 500, "t5_saturacao");
    check("t5_medida_999", 32'(medida), 32'h999);

    // sweep over both channels
    exp_q.push_back(esperado(0, 74 * C + 6));
    exp_q.push_back(esperado(1, 100 * C + 2));
    iniciar(1'b1, 1);
    medicao(0, 74 * C + 6, "t6_varre_ch0");
    pr0 = last_pr_cyc;
    medicao(1, 100 * C + 2, "t6_varre_ch1");
    check("t6_intervalo", trig_cyc - pr0, INT + 2);
    check("t6_fim_inicial", 32'(db_estado), 32'd0);

    // randomized single-channel measurements
    for (int k = 0; k < 6; k++) begin
      ch = $urandom_range(0, 1);
      w = $urandom_range(0, 200) * C + (($urandom_range(0, 1) == 1) ? 6 : 2);
      exp_q.push_back(esperado(ch, w));
      iniciar(1'b0, ch);
      medicao(ch, w, $sformatf("rnd%0d", k));
    end

    // asynchronous reset in the middle of MEDE
    iniciar(1'b0, 1);
    n = 0;
    while (!trigger[1] && n < 200) begin tick(); n++; end
    n = 0;
    while (trigger != '0 && n < 200) begin tick(); n++; end
    echo[1] = 1'b1;
    repeat (100) tick();
    check("t7_em_mede", 32'(db_estado), 32'd4);
    #2;
    reset = 1'b1;
    #1;
    check("t7_rst_estado", 32'(db_estado), 32'd0);
    check("t7_rst_ocupado", 32'(ocupado), 32'd0);
    check("t7_rst_trigger", 32'(trigger), 32'd0);
    check("t7_rst_pronto", 32'(pronto), 32'd0);
    check("t7_rst_medida", 32'(medida), 32'h000);
    check("t7_rst_canal", 32'(canal_medida), 32'd0);
    check("t7_rst_timeout", 32'(timeout), 32'd0);
    echo = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    exp_q.push_back(esperado(1, 100 * C + 2));
    iniciar(1'b0, 1);
    medicao(1, 100 * C + 2, "t7_pos_reset");

    check("fila_vazia_final", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
